// File: rtl/freq_calc_if.sv
// freq_calc handshake bundle: count pair in, frequency result out.
// slave modport is the calculator side, master is the producer/consumer side.
interface freq_calc_if #(
   parameter int unsigned CNT_W = 32
) ();
   logic [CNT_W-1:0] ref_cnt;
   logic [CNT_W-1:0] meas_cnt;
   logic             cnt_valid;
   logic             cnt_ready;
   logic [31:0]      freq_hz;
   logic             freq_valid;
   logic             freq_ready;
   logic             div_zero;
   logic             sat;

   modport slave (
      input  ref_cnt,
      input  meas_cnt,
      input  cnt_valid,
      output cnt_ready,
      output freq_hz,
      output freq_valid,
      input  freq_ready,
      output div_zero,
      output sat
   );

   modport master (
      output ref_cnt,
      output meas_cnt,
      output cnt_valid,
      input  cnt_ready,
      input  freq_hz,
      input  freq_valid,
      output freq_ready,
      input  div_zero,
      input  sat
   );
endinterface

// File: rtl/freq_calc.sv
// Reciprocal-count post-processor: freq_hz = meas_cnt * F_REF_HZ / ref_cnt.
// Optional FREQ_CALC_ROUND_EN adds ref_cnt>>1 to round half up.
module freq_calc #(
   parameter logic [31:0] F_REF_HZ = 32'd10_000_000,
   parameter int unsigned CNT_W    = 32
) (
   input  logic        clk_ref,
   input  logic        sys_rst,
   freq_calc_if.slave  bus,
   output logic        busy
);
   localparam int unsigned N  = CNT_W + 32;
   localparam int unsigned BW = $clog2(N);

   typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

   state_t           state_q, state_d;
   logic [CNT_W-1:0] ref_q, ref_d;
   logic [CNT_W-1:0] meas_q, meas_d;
   logic [N-1:0]     num_q, num_d;
   logic [CNT_W:0]   rem_q, rem_d;
   logic [BW-1:0]    bit_q, bit_d;
   logic [31:0]      freq_hz_q, freq_hz_d;
   logic             div_zero_q, div_zero_d;
   logic             sat_q, sat_d;
   logic             freq_valid_q, freq_valid_d;

   logic [CNT_W:0]   rem_sh;
   logic             q_bit;
   logic [N-1:0]     num_sh;
   logic [N-1:0]     prod;

   // Next-state logic; num_q shifts the dividend out and the quotient in.
   always_comb begin
      state_d      = state_q;
      ref_d        = ref_q;
      meas_d       = meas_q;
      num_d        = num_q;
      rem_d        = rem_q;
      bit_d        = bit_q;
      freq_hz_d    = freq_hz_q;
      div_zero_d   = div_zero_q;
      sat_d        = sat_q;
      freq_valid_d = freq_valid_q;

      // remainder < divisor, so its top bit is always zero before the shift
      rem_sh = {rem_q[CNT_W-1:0], num_q[N-1]};
      q_bit  = (rem_sh >= {1'b0, ref_q});
      num_sh = {num_q[N-2:0], q_bit};
      prod   = N'(meas_q) * N'(F_REF_HZ);

      unique case (state_q)
         IDLE: begin
            if (bus.cnt_valid) begin
               ref_d   = bus.ref_cnt;
               meas_d  = bus.meas_cnt;
               state_d = MUL;
            end
         end
         MUL: begin
            if (ref_q == '0) begin
               freq_hz_d    = '0;
               div_zero_d   = 1'b1;
               sat_d        = 1'b0;
               freq_valid_d = 1'b1;
               state_d      = DONE;
            end else begin
`ifdef FREQ_CALC_ROUND_EN
               num_d = prod + N'(ref_q >> 1);
`else
               num_d = prod;
`endif
               rem_d   = '0;
               bit_d   = BW'(N - 1);
               state_d = DIV;
            end
         end
         DIV: begin
            rem_d = q_bit ? (rem_sh - {1'b0, ref_q}) : rem_sh;
            num_d = num_sh;
            bit_d = bit_q - BW'(1);
            if (bit_q == '0) begin
               if (|num_sh[N-1:32]) begin
                  freq_hz_d = 32'hFFFF_FFFF;
                  sat_d     = 1'b1;
               end else begin
                  freq_hz_d = num_sh[31:0];
                  sat_d     = 1'b0;
               end
               div_zero_d   = 1'b0;
               freq_valid_d = 1'b1;
               state_d      = DONE;
            end
         end
         DONE: begin
            if (bus.freq_ready) begin
               freq_valid_d = 1'b0;
               state_d      = IDLE;
            end
         end
      endcase
   end

   // State and datapath registers, cleared asynchronously.
   always_ff @(posedge clk_ref or posedge sys_rst) begin
      if (sys_rst) begin
         state_q      <= IDLE;
         ref_q        <= '0;
         meas_q       <= '0;
         num_q        <= '0;
         rem_q        <= '0;
         bit_q        <= '0;
         freq_hz_q    <= '0;
         div_zero_q   <= 1'b0;
         sat_q        <= 1'b0;
         freq_valid_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         ref_q        <= ref_d;
         meas_q       <= meas_d;
         num_q        <= num_d;
         rem_q        <= rem_d;
         bit_q        <= bit_d;
         freq_hz_q    <= freq_hz_d;
         div_zero_q   <= div_zero_d;
         sat_q        <= sat_d;
         freq_valid_q <= freq_valid_d;
      end
   end

   assign bus.cnt_ready  = (state_q == IDLE);
   assign bus.freq_valid = freq_valid_q;
   assign bus.freq_hz    = freq_hz_q;
   assign bus.div_zero   = div_zero_q;
   assign bus.sat        = sat_q;
   assign busy           = (state_q != IDLE);
endmodule

// File: tb/tb_freq_calc.sv
// Bench for freq_calc: directed cases plus random pairs against an
// arithmetic reference model.
module tb_freq_calc;
   localparam logic [31:0] F_REF = 32'd10_000_000;

   logic clk;
   logic rst;
   logic busy;
   int   checks;
   int   fails;

   freq_calc_if #(.CNT_W(32)) bus ();

   freq_calc #(.F_REF_HZ(F_REF), .CNT_W(32)) dut (
      .clk_ref (clk),
      .sys_rst (rst),
      .bus     (bus),
      .busy    (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic void model(input logic [31:0] r, input logic [31:0] m,
                                 output logic [31:0] f, output logic s,
                                 output logic d);
      logic [63:0] num;
      logic [63:0] q;
      if (r == 32'd0) begin
         f = 32'd0;
         s = 1'b0;
         d = 1'b1;
      end else begin
         num = 64'(m) * 64'(F_REF);
`ifdef FREQ_CALC_ROUND_EN
         num = num + 64'(r / 2);
`endif
         q = num / 64'(r);
         d = 1'b0;
         if (q > 64'h0000_0000_FFFF_FFFF) begin
            f = 32'hFFFF_FFFF;
            s = 1'b1;
         end else begin
            f = q[31:0];
            s = 1'b0;
         end
      end
   endfunction

   // Present a pair and return #1 after its accept edge (E0).
   task automatic send(input logic [31:0] r, input logic [31:0] m);
      int g;
      g = 0;
      @(negedge clk);
      bus.ref_cnt   = r;
      bus.meas_cnt  = m;
      bus.cnt_valid = 1'b1;
      while (!bus.cnt_ready && g < 200) begin
         @(negedge clk);
         g++;
      end
      checks++;
      if (g >= 200) begin
         fails++;
         $display("FAIL send_timeout cnt_ready=%b required=1", bus.cnt_ready);
      end
      @(posedge clk);
      #1;
      bus.cnt_valid = 1'b0;
      bus.ref_cnt   = $urandom;
      bus.meas_cnt  = $urandom;
   endtask

   // Count edges after E0 until freq_valid is seen (bounded).
   task automatic wait_valid(output int edges);
      edges = 0;
      while (!bus.freq_valid && edges < 200) begin
         @(posedge clk);
         #1;
         edges++;
      end
   endtask

   task automatic transfer();
      bus.freq_ready = 1'b1;
      @(posedge clk);
      #1;
      bus.freq_ready = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      #1;
      checks++; if (bus.cnt_ready !== 1'b1) begin fails++; $display("FAIL rst_cnt_ready got=%b required=1", bus.cnt_ready); end
      checks++; if (bus.freq_valid !== 1'b0) begin fails++; $display("FAIL rst_freq_valid got=%b required=0", bus.freq_valid); end
      checks++; if (bus.freq_hz !== 32'd0) begin fails++; $display("FAIL rst_freq_hz got=%h required=0", bus.freq_hz); end
      checks++; if (bus.div_zero !== 1'b0) begin fails++; $display("FAIL rst_div_zero got=%b required=0", bus.div_zero); end
      checks++; if (bus.sat !== 1'b0) begin fails++; $display("FAIL rst_sat got=%b required=0", bus.sat); end
      checks++; if (busy !== 1'b0) begin fails++; $display("FAIL rst_busy got=%b required=0", busy); end
      repeat (2) @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_known();
      int e;
      send(32'd10_000_000, 32'd1_000_000);
      checks++; if (busy !== 1'b1 || bus.cnt_ready !== 1'b0) begin fails++; $display("FAIL known_busy busy=%b cnt_ready=%b required 1/0", busy, bus.cnt_ready); end
      wait_valid(e);
      checks++; if (e != 65) begin fails++; $display("FAIL known_latency got=%0d required=65", e); end
      checks++; if (bus.freq_hz !== 32'd1_000_000) begin fails++; $display("FAIL known_freq got=%0d required=1000000", bus.freq_hz); end
      checks++; if (bus.sat !== 1'b0 || bus.div_zero !== 1'b0) begin fails++; $display("FAIL known_flags sat=%b dz=%b required 0/0", bus.sat, bus.div_zero); end
      transfer();
      checks++; if (bus.freq_valid !== 1'b0 || bus.cnt_ready !== 1'b1) begin fails++; $display("FAIL known_xfer valid=%b cnt_ready=%b required 0/1", bus.freq_valid, bus.cnt_ready); end
      checks++; if (bus.freq_hz !== 32'd1_000_000) begin fails++; $display("FAIL known_hold got=%0d required=1000000", bus.freq_hz); end
   endtask

   task automatic test_round();
      int          e;
      logic [31:0] want;
`ifdef FREQ_CALC_ROUND_EN
      want = 32'd6_666_667;
`else
      want = 32'd6_666_666;
`endif
      send(32'd3, 32'd2);
      wait_valid(e);
      checks++; if (bus.freq_hz !== want) begin fails++; $display("FAIL round_freq got=%0d required=%0d", bus.freq_hz, want); end
      transfer();
   endtask

   task automatic test_div_zero();
      int e;
      send(32'd0, 32'd123);
      wait_valid(e);
      checks++; if (e != 1) begin fails++; $display("FAIL dz_latency got=%0d required=1", e); end
      checks++; if (bus.freq_hz !== 32'd0 || bus.div_zero !== 1'b1 || bus.sat !== 1'b0) begin fails++; $display("FAIL dz_result freq=%h dz=%b sat=%b required 0/1/0", bus.freq_hz, bus.div_zero, bus.sat); end
      transfer();
   endtask

   task automatic test_sat();
      int e;
      send(32'd1, 32'hFFFF_FFFF);
      wait_valid(e);
      checks++; if (bus.freq_hz !== 32'hFFFF_FFFF || bus.sat !== 1'b1 || bus.div_zero !== 1'b0) begin fails++; $display("FAIL sat_result freq=%h sat=%b dz=%b required ffffffff/1/0", bus.freq_hz, bus.sat, bus.div_zero); end
      checks++; if (e != 65) begin fails++; $display("FAIL sat_latency got=%0d required=65", e); end
      transfer();
   endtask

   task automatic test_random();
      logic [31:0] r, m, ef;
      logic        es, ed;
      int          e, sel, early;
      for (int i = 0; i < 24; i++) begin
         sel = $urandom_range(0, 4);
         m   = $urandom;
         case (sel)
            0: r = 32'($urandom_range(1, 15));
            1: r = 32'd0;
            2: r = 32'($urandom_range(1_000_000, 20_000_000));
            default: r = $urandom;
         endcase
         if (sel == 2) m = 32'($urandom_range(0, 50_000_000));
         model(r, m, ef, es, ed);
         early = $urandom_range(0, 1);
         bus.freq_ready = early[0];
         send(r, m);
         wait_valid(e);
         checks++; if (e != ((r == 0) ? 1 : 65)) begin fails++; $display("FAIL rand_latency i=%0d got=%0d", i, e); end
         checks++; if (bus.freq_hz !== ef || bus.sat !== es || bus.div_zero !== ed) begin fails++; $display("FAIL rand_result r=%0d m=%0d got=%0d/%b/%b required=%0d/%b/%b", r, m, bus.freq_hz, bus.sat, bus.div_zero, ef, es, ed); end
         if (early == 0) begin
            repeat ($urandom_range(0, 3)) @(posedge clk);
            #1;
            bus.freq_ready = 1'b1;
         end
         @(posedge clk);
         #1;
         bus.freq_ready = 1'b0;
         checks++; if (bus.freq_valid !== 1'b0) begin fails++; $display("FAIL rand_xfer i=%0d valid=%b required=0", i, bus.freq_valid); end
      end
   endtask

   task automatic test_back_to_back();
      logic [31:0] ra, ma, fa, rb, mb, fb;
      logic        sa, da, sb, db;
      int          e;
      ra = 32'($urandom_range(5_000_000, 15_000_000));
      ma = 32'($urandom_range(1, 30_000_000));
      rb = 32'd2;
      mb = 32'hF000_0000;
      model(ra, ma, fa, sa, da);
      model(rb, mb, fb, sb, db);
      send(ra, ma);
      wait_valid(e);
      bus.ref_cnt   = rb;
      bus.meas_cnt  = mb;
      bus.cnt_valid = 1'b1;
      for (int i = 0; i < 10; i++) begin
         @(posedge clk);
         #1;
         checks++; if (bus.freq_valid !== 1'b1 || bus.freq_hz !== fa || bus.cnt_ready !== 1'b0) begin fails++; $display("FAIL b2b_hold i=%0d valid=%b freq=%0d cnt_ready=%b required 1/%0d/0", i, bus.freq_valid, bus.freq_hz, bus.cnt_ready, fa); end
      end
      transfer();
      checks++; if (bus.freq_valid !== 1'b0 || bus.cnt_ready !== 1'b1 || busy !== 1'b0) begin fails++; $display("FAIL b2b_xfer valid=%b cnt_ready=%b busy=%b required 0/1/0", bus.freq_valid, bus.cnt_ready, busy); end
      @(posedge clk);
      #1;
      bus.cnt_valid = 1'b0;
      bus.meas_cnt  = $urandom;
      checks++; if (busy !== 1'b1) begin fails++; $display("FAIL b2b_accept busy=%b required=1", busy); end
      wait_valid(e);
      checks++; if (e != 65) begin fails++; $display("FAIL b2b_latency got=%0d required=65", e); end
      checks++; if (bus.freq_hz !== fb || bus.sat !== sb) begin fails++; $display("FAIL b2b_second got=%h/%b required=%h/%b", bus.freq_hz, bus.sat, fb, sb); end
      transfer();
   endtask

   task automatic test_reset_mid();
      logic [31:0] r, m, f;
      logic        s, d;
      int          e, seen;
      send(32'd7_000_000, 32'd3_500_000);
      repeat (30) @(posedge clk);
      #1;
      rst = 1'b1;
      #1;
      checks++; if (bus.freq_hz !== 32'd0 || bus.sat !== 1'b0 || bus.div_zero !== 1'b0) begin fails++; $display("FAIL mid_rst_data freq=%h sat=%b dz=%b required 0/0/0", bus.freq_hz, bus.sat, bus.div_zero); end
      checks++; if (bus.freq_valid !== 1'b0 || bus.cnt_ready !== 1'b1 || busy !== 1'b0) begin fails++; $display("FAIL mid_rst_ctrl valid=%b cnt_ready=%b busy=%b required 0/1/0", bus.freq_valid, bus.cnt_ready, busy); end
      repeat (2) @(negedge clk);
      rst  = 1'b0;
      seen = 0;
      for (int i = 0; i < 50; i++) begin
         @(posedge clk);
         #1;
         if (bus.freq_valid === 1'b1) seen++;
      end
      checks++; if (seen != 0) begin fails++; $display("FAIL mid_rst_discard valid_cycles=%0d required=0", seen); end
      r = 32'($urandom_range(1_000_000, 12_000_000));
      m = 32'($urandom_range(1, 40_000_000));
      model(r, m, f, s, d);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst           = 1'b0;
      bus.ref_cnt   = r;
      bus.meas_cnt  = m;
      bus.cnt_valid = 1'b1;
      @(posedge clk);
      #1;
      bus.cnt_valid = 1'b0;
      checks++; if (busy !== 1'b1) begin fails++; $display("FAIL post_rst_accept busy=%b required=1", busy); end
      wait_valid(e);
      checks++; if (e != 65 || bus.freq_hz !== f) begin fails++; $display("FAIL post_rst_result edges=%0d freq=%0d required 65/%0d", e, bus.freq_hz, f); end
      transfer();
   endtask

   initial begin
      checks         = 0;
      fails          = 0;
      rst            = 1'b1;
      bus.ref_cnt    = '0;
      bus.meas_cnt   = '0;
      bus.cnt_valid  = 1'b0;
      bus.freq_ready = 1'b0;
      test_reset();
      test_known();
      test_round();
      test_div_zero();
      test_sat();
      test_random();
      test_back_to_back();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog time limit reached");
      $fatal(1, "watchdog");
   end
endmodule
